// File: rtl/lc3_pkg.sv
// Shared types and width helpers for the LC-3 memory access sequencer.
package lc3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_t;

    // Bits needed to hold values 0..n-1, never less than one so degenerate
    // configurations still get a real register.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lc3_rr_arbiter.sv
// Round-robin pick: first requester found searching upward from ptr+1, wrapping.
// Purely combinational; the caller owns the pointer.
module lc3_rr_arbiter
    import lc3_pkg::*;
#(
    parameter int N_CH = 2
) (
    input  logic [N_CH-1:0]                 req_i,
    input  logic [clog2_min1(N_CH)-1:0]     ptr_i,
    output logic [N_CH-1:0]                 win_o,
    output logic                            vld_o
);

    logic found;
    int   idx;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(ptr_i) + i) % N_CH;
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign vld_o = |req_i;

endmodule

// File: rtl/lc3_mem_arbiter_fsm.sv
// Round-robin sequencer owning the single CS/WE/READY memory port; one access at a time.
// Grant one edge after req, done/err pulse one edge after READY or timeout, one IDLE cycle between accesses.
module lc3_mem_arbiter_fsm
    import lc3_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          we,
    input  logic [N_CH*ADDR_W-1:0]   addr,
    input  logic [N_CH*DATA_W-1:0]   wdata,
    output logic [N_CH-1:0]          gnt,
    output logic [N_CH-1:0]          done,
    output logic [N_CH-1:0]          err,
    output logic [DATA_W-1:0]        rdata,
    output logic                     MEM_CS,
    output logic                     MEM_WE,
    output logic [ADDR_W-1:0]        MEM_ADDR,
    output logic [DATA_W-1:0]        MEM_WDATA,
    input  logic [DATA_W-1:0]        MEM_RDATA,
    input  logic                     MEM_READY
);

    localparam int PTR_W = clog2_min1(N_CH);
    localparam int CNT_W = clog2_min1(TIMEOUT + 1);

    mem_state_t          state_q,     state_d;
    logic [N_CH-1:0]     gnt_q,       gnt_d;
    logic [N_CH-1:0]     done_q,      done_d;
    logic [N_CH-1:0]     err_q,       err_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic                mem_cs_q,    mem_cs_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [PTR_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    logic [N_CH-1:0]     win;
    logic                win_vld;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [PTR_W-1:0]    win_idx;
    logic                timeout_hit;

    lc3_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .win_o (win),
        .vld_o (win_vld)
    );

    // One-hot winner drives the request mux and becomes the next pointer.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        win_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (win[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
                win_idx   = PTR_W'(i);
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = done_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_cs_d    = mem_cs_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                done_d      = '0;
                err_d       = '0;
                mem_cs_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                cnt_d       = '0;
                if (win_vld) begin
                    gnt_d       = win;
                    mem_cs_d    = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    rr_ptr_d    = win_idx;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // READY takes priority over a timeout landing on the same cycle.
                if (MEM_READY) begin
                    if (!mem_we_q) begin
                        rdata_d = MEM_RDATA;
                    end
                    mem_cs_d = 1'b0;
                    mem_we_d = 1'b0;
                    done_d   = gnt_q;
                    state_d  = RESP;
                end else if (timeout_hit) begin
                    mem_cs_d = 1'b0;
                    mem_we_d = 1'b0;
                    done_d   = gnt_q;
                    err_d    = gnt_q;
                    state_d  = RESP;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                gnt_d       = '0;
                done_d      = '0;
                err_d       = '0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rr_ptr_q    <= PTR_W'(N_CH - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign MEM_CS    = mem_cs_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;

endmodule
